// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control FSM with MemReady timeout trap
// Define MCCTRL_JALR_LUI_EN to add the JALR and LUI states.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Trap,
  output logic       MemErr,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
`ifdef MCCTRL_JALR_LUI_EN
    ,
    JALR     = 4'd12,
    LUI      = 4'd13
`endif
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
`ifdef MCCTRL_JALR_LUI_EN
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             memerr;
  logic             waiting;
  logic             timeout;

  assign waiting = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  // The WAIT_MAX-th idle cycle traps; MemReady on that same cycle still completes.
  assign timeout = waiting && !MemReady && (cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      cnt    <= '0;
      memerr <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (timeout) memerr <= 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCUpdate  = MemReady;
        state_n   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_R:         state_n = EXECR;
          OP_I:         state_n = EXECI;
          OP_BEQ:       state_n = BEQ;
          OP_JAL:       state_n = JAL;
`ifdef MCCTRL_JALR_LUI_EN
          OP_JALR:      state_n = JALR;
          OP_LUI:       state_n = LUI;
`endif
          default:      state_n = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_n = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_n = MemReady ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_n  = MemReady ? FETCH : MEMWRITE;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_n   = FETCH;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_n  = FETCH;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        Branch  = 1'b1;
        state_n = FETCH;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCUpdate = 1'b1;
        state_n  = ALUWB;
      end
`ifdef MCCTRL_JALR_LUI_EN
      JALR: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        PCUpdate = 1'b1;
        state_n  = ALUWB;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_n = ALUWB;
      end
`endif
      default: state_n = TRAP;
    endcase
    if (timeout) state_n = TRAP;
  end

  // Counter only runs while a memory-wait state holds; any transition clears it.
  always_comb begin
    cnt_n = '0;
    if (waiting && !MemReady && (state_n == state)) cnt_n = cnt + 1'b1;
  end

  always_comb begin
    ImmSrc = 2'b00;
    if (state != TRAP) begin
      case (op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BEQ:  ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
`ifdef MCCTRL_JALR_LUI_EN
        OP_JALR: ImmSrc = 2'b11;
`endif
        default: ImmSrc = 2'b00;
      endcase
    end
  end

  assign Trap   = (state == TRAP);
  assign MemErr = memerr;
  assign State  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
// Expected behaviour follows per-opcode state paths; honours MCCTRL_JALR_LUI_EN.
module tb_multicycle_ctrl;
  localparam int WAIT_MAX = 4;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       MemReady;
  logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       Trap, MemErr;
  logic [3:0] State;

  int   errors = 0;
  int   checks = 0;
  logic me = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .MemReady(MemReady),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Trap(Trap), .MemErr(MemErr),
    .State(State)
  );

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected outputs {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,
  // ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Trap,MemErr} from the state table.
  function automatic logic [17:0] exp_vec(input int s, input logic mr,
                                          input logic [6:0] o, input logic err);
    logic pcu, br, rw, mw, irw, adr;
    logic [1:0] rs, sa, sb, aop, imm;
    {pcu, br, rw, mw, irw, adr} = 6'b0;
    {rs, sa, sb, aop} = 8'b0;
    imm = 2'b00;
    if (o == OP_SW) imm = 2'b01;
    else if (o == OP_BEQ) imm = 2'b10;
    else if (o == OP_JAL) imm = 2'b11;
`ifdef MCCTRL_JALR_LUI_EN
    else if (o == OP_JALR) imm = 2'b11;
`endif
    case (s)
      0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
      1:  begin sa = 2'b01; sb = 2'b01; end
      2:  begin sa = 2'b10; sb = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin sa = 2'b10; aop = 2'b10; end
      7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      8:  rw = 1'b1;
      9:  begin sa = 2'b10; aop = 2'b01; br = 1'b1; end
      10: begin sa = 2'b01; sb = 2'b10; pcu = 1'b1; end
      12: begin sa = 2'b10; sb = 2'b01; pcu = 1'b1; end
      13: begin sa = 2'b11; sb = 2'b01; end
      default: imm = 2'b00;
    endcase
    if (s == 11) return {16'b0, 1'b1, err};
    return {pcu, br, rw, mw, irw, adr, rs, sa, sb, aop, imm, 1'b0, 1'b0};
  endfunction

  task automatic chk(input int s, input logic mr);
    logic [17:0] got, exp;
    MemReady = mr;
    #1;
    got = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
           ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Trap, MemErr};
    exp = exp_vec(s, mr, op, me);
    checks++;
    assert (State === 4'(s)) else begin
      errors++;
      $error("FAIL state: got %0d expected %0d (op %b)", State, s, op);
    end
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL outputs state %0d: got %h expected %h (op %b mr %b)", s, got, exp, op, mr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    MemReady = rnd();
    @(posedge clk);
    #1;
    reset = 1'b0;
    me = 1'b0;
  endtask

  // wf / wm: idle MemReady cycles in FETCH / in the data-memory state.
  task automatic run_instr(input logic [6:0] o, input int wf, input int wm);
    int path[$];
    int s;
    int w;
    op = o;
    case (o)
      OP_LW:   path = {0, 1, 2, 3, 4};
      OP_SW:   path = {0, 1, 2, 5};
      OP_R:    path = {0, 1, 6, 8};
      OP_I:    path = {0, 1, 7, 8};
      OP_BEQ:  path = {0, 1, 9};
      OP_JAL:  path = {0, 1, 10, 8};
`ifdef MCCTRL_JALR_LUI_EN
      OP_JALR: path = {0, 1, 12, 8};
      OP_LUI:  path = {0, 1, 13, 8};
`endif
      default: path = {0, 1, 11};
    endcase
    foreach (path[k]) begin
      s = path[k];
      if (s == 11) begin
        repeat (3) chk(11, rnd());
        do_reset();
        return;
      end
      if (s == 0 || s == 3 || s == 5) begin
        w = (s == 0) ? wf : wm;
        for (int i = 0; i < w && i < WAIT_MAX; i++) chk(s, 1'b0);
        if (w >= WAIT_MAX) begin
          me = 1'b1;
          repeat (3) chk(11, rnd());
          do_reset();
          return;
        end
        chk(s, 1'b1);
      end else begin
        chk(s, rnd());
      end
    end
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [6:0] o;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR, OP_LUI};
    reset = 1'b1;
    op = OP_LW;
    MemReady = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 2);
    run_instr(OP_LW, WAIT_MAX, 0);
    run_instr(OP_JALR, 0, 0);
    run_instr(OP_LW, 0, WAIT_MAX - 1);
    run_instr(OP_SW, WAIT_MAX - 1, WAIT_MAX);
    run_instr(OP_LW, 0, WAIT_MAX);
    foreach (ops[k]) run_instr(ops[k], 0, 0);
    run_instr(7'h7f, 1, 0);

    op = OP_R;
    repeat (3) chk(0, 1'b0);
    reset = 1'b1;
    chk(0, 1'b0);
    reset = 1'b0;
    run_instr(OP_R, WAIT_MAX - 1, 0);

    op = OP_LW;
    chk(0, 1'b1);
    chk(1, rnd());
    chk(2, rnd());
    chk(3, 1'b0);
    chk(3, 1'b0);
    reset = 1'b1;
    chk(3, 1'b0);
    reset = 1'b0;
    me = 1'b0;
    run_instr(OP_I, 0, 0);

    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(0, 8) == 8) ? 7'($urandom_range(0, 127)) : ops[$urandom_range(0, 7)];
      run_instr(o,
                ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1),
                ($urandom_range(0, 9) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 4, giving the maximum number of consecutive cycles a memory state waits for MemReady before trapping (range 1..255).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the wait-counter width; WAIT_MAX SHALL be at most 2^CNT_W-1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port op, input, 7 bits: opcode field of the instruction register.
REQ-006 Port MemReady, input, 1 bit: memory completes the current access this cycle.
REQ-007 Outputs, all registered-state-derived (Moore) except ImmSrc and the MemReady-gated strobes: PCUpdate (1), Branch (1), RegWrite (1), MemWrite (1), IRWrite (1), AdrSrc (1), ResultSrc (2), ALUSrcA (2), ALUSrcB (2), ALUOp (2), ImmSrc (2).
REQ-008 Outputs Trap (1), MemErr (1) and State (4): sticky illegal-opcode or timeout flag, timeout cause, and current state for debug.

Function
REQ-009 States and encodings SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
REQ-010 Outputs not listed for a state SHALL be 0; no output SHALL ever be X.
REQ-011 FETCH SHALL drive AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite and PCUpdate SHALL equal MemReady; the next state SHALL be DECODE when MemReady=1, else FETCH.
REQ-012 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00, then branch on op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, any other->TRAP.
REQ-013 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, and go to MEMREAD if op=0000011, else MEMWRITE.
REQ-014 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00, and go to MEMWB on MemReady=1, else hold.
REQ-015 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held, and go to FETCH on MemReady=1, else hold.
REQ-016 MEMWB SHALL drive ResultSrc=01, RegWrite=1, then go to FETCH.
REQ-017 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=10; both SHALL go to ALUWB.
REQ-018 ALUWB SHALL drive ResultSrc=00, RegWrite=1, then go to FETCH.
REQ-019 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
REQ-020 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then go to ALUWB.
REQ-021 ImmSrc SHALL be combinational from op: I-type/load 00, store 01, branch 10, jal 11, others 00.
REQ-022 A wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and increment each cycle those states hold with MemReady=0.
REQ-023 If the counter reaches WAIT_MAX while MemReady=0, the next state SHALL be TRAP with MemErr=1; MemReady=1 on that same cycle SHALL win and complete normally.
REQ-024 TRAP SHALL be absorbing: all control outputs 0, Trap=1, MemErr held; exit only by reset.
REQ-025 Instruction latency SHALL be, with MemReady=1 throughout: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.

Reset
REQ-026 With reset=1 at a clock edge, in any state including mid-wait, the block SHALL enter FETCH and clear the counter, Trap and MemErr.
REQ-027 After reset, outputs SHALL be the FETCH values of REQ-011.

Configuration
REQ-028 With macro MCCTRL_JALR_LUI_EN defined, the block SHALL add states JALR=12 and LUI=13.
REQ-029 In DECODE under that macro, op=1100111 SHALL go to JALR and op=0110111 to LUI.
REQ-030 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, PCUpdate=1, ResultSrc=00, then go to ALUWB.
REQ-031 LUI SHALL drive ALUSrcA=11, ALUSrcB=01, ALUOp=00, then go to ALUWB, and ImmSrc SHALL be 11 for jalr and 00 for lui.
REQ-032 Without the macro, states 12/13 SHALL not exist and both opcodes SHALL go to TRAP.

Verification
REQ-033 reset, MemReady=1, op=0000011 -> State 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-034 op=0100011, MemReady low 2 cycles in MEMWRITE -> MemWrite=1 for 3 cycles, then FETCH.
REQ-035 WAIT_MAX=4, MemReady=0 in FETCH -> TRAP after 4 wait cycles, Trap=1, MemErr=1, IRWrite never 1.
REQ-036 op=1100111 without the macro -> TRAP, MemErr=0; with the macro -> 0,1,12,8,0 with PCUpdate=1 in state 12.
REQ-037 reset asserted in MEMREAD mid-wait -> FETCH next cycle, counter 0, Trap 0.
